// File: rtl/period_meter.sv
// Period meter: counts CLKin cycles between rising edges of an asynchronous input.
// Single-shot or continuous; a timeout flags dead or too-slow inputs.
//
// state   | meaning
// IDLE    | waiting for start; edges ignored
// ARM     | waiting for the first rising edge of sig_in
// MEASURE | counting cycles until the next rising edge
module period_meter #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000000
) (
  input  logic             CLKin,
  input  logic             clr,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic                   busy_q, busy_d;
  logic                   edge_p;

  // Shift sig_in through the synchronizer; the history flop gives a one-cycle rise pulse.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  assign hist_d = sync_q[SYNC_STAGES-1];
  assign edge_p = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (edge_p) begin
          state_d = MEASURE;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == TIMEOUT_C) begin
          state_d  = IDLE;
          cnt_d    = '0;
          period_d = '0;
          ovf_d    = 1'b1;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEASURE: begin
        // An edge on the timeout cycle still yields a normal result.
        if (edge_p) begin
          period_d = cnt_q;
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
          if (cont) begin
            cnt_d = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          state_d  = IDLE;
          cnt_d    = '0;
          period_d = '0;
          ovf_d    = 1'b1;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ARM) || (state_d == MEASURE);
  end

  always_ff @(posedge CLKin or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      hist_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign period   = period_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: expected results are queued when stimulus
// is driven and compared (value, flags, latency) when valid pulses.
module tb_period_meter;

  localparam int CNT_W = 32;

  logic             CLKin = 1'b0;
  logic             clr   = 1'b0;
  logic             sig_in = 1'b0;
  logic             start = 1'b0;
  logic             cont  = 1'b0;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             overflow;
  logic             busy;

  period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(1000)) dut (
    .CLKin(CLKin), .clr(clr), .sig_in(sig_in), .start(start), .cont(cont),
    .period(period), .valid(valid), .overflow(overflow), .busy(busy)
  );

  always #5 CLKin = ~CLKin;

  typedef struct {
    logic [31:0] per;
    logic        ovf;
    logic        bsy;
    int          rel;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   base_cyc = 0;
  int   n_valid = 0;
  int   n0;

  // square-wave generator state, advanced once per tick
  bit   sq_en = 1'b0;
  int   ph = 0;
  int   lo_len = 50;
  int   hi_len = 50;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge CLKin) cyc <= cyc + 1;

  always @(negedge CLKin) begin
    if (valid) begin
      exp_t e;
      n_valid++;
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("period", period, e.per);
        chk("overflow", overflow, e.ovf);
        chk("busy_at_valid", busy, e.bsy);
        chk("latency", cyc - base_cyc, e.rel);
      end
    end
  end

  task automatic tick();
    @(negedge CLKin);
    #1;
    if (sq_en) begin
      ph++;
      if (ph == lo_len) sig_in = 1'b1;
      else if (ph == lo_len + hi_len) begin
        sig_in = 1'b0;
        ph = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sq_restart(input int lo, input int hi);
    lo_len = lo;
    hi_len = hi;
    ph     = 0;
    sig_in = 1'b0;
    sq_en  = 1'b1;
  endtask

  task automatic pulse_start();
    start    = 1'b1;
    base_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [31:0] p, input logic o, input logic b, input int r);
    exp_t e;
    e.per = p; e.ovf = o; e.bsy = b; e.rel = r;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 3000) begin
      tick();
      k++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    idle(3);
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    clr = 1'b1;
    idle(5);

    // single shot, period 100: first edge reaches e 52 cycles after start
    n0 = n_valid;
    sq_restart(50, 50);
    push(100, 0, 0, 153);
    pulse_start();
    drain("t1");
    idle(300);
    chk("t1_nvalid", n_valid - n0, 1);
    chk("t1_busy_idle", busy, 0);

    // continuous: three results, cont dropped, one more
    n0 = n_valid;
    cont = 1'b1;
    sq_restart(50, 50);
    push(100, 0, 1, 153);
    push(100, 0, 1, 253);
    push(100, 0, 1, 353);
    push(100, 0, 0, 453);
    pulse_start();
    idle(401);
    cont = 1'b0;
    drain("t2");
    idle(300);
    chk("t2_nvalid", n_valid - n0, 4);
    chk("t2_busy_idle", busy, 0);

    // dead input: timeout in ARM
    sq_en  = 1'b0;
    sig_in = 1'b0;
    push(0, 1, 0, 1002);
    pulse_start();
    drain("t3");
    idle(20);

    // period 2000: timeout in MEASURE
    sq_restart(10, 1990);
    push(0, 1, 0, 1013);
    pulse_start();
    drain("t4");
    idle(1100);

    // period 1001: one past the limit
    sq_restart(10, 991);
    push(0, 1, 0, 1013);
    pulse_start();
    drain("t5a");
    idle(100);

    // period 1000: edge on the timeout cycle wins
    sq_restart(10, 990);
    push(1000, 0, 0, 1013);
    pulse_start();
    drain("t5b");
    idle(100);

    // reset mid-MEASURE
    n0 = n_valid;
    sq_restart(50, 50);
    pulse_start();
    idle(99);
    chk("t6_busy_before", busy, 1);
    clr = 1'b0;
    #1;
    chk("t6_period", period, 0);
    chk("t6_valid", valid, 0);
    chk("t6_overflow", overflow, 0);
    chk("t6_busy", busy, 0);
    idle(3);
    chk("t6_nvalid", n_valid - n0, 0);
    clr = 1'b1;
    idle(5);
    sq_restart(50, 50);
    push(100, 0, 0, 153);
    pulse_start();
    drain("t6");
    idle(50);

    // start while busy must not restart the measurement
    sq_restart(50, 50);
    push(100, 0, 0, 153);
    pulse_start();
    idle(79);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain("t7");
    idle(50);

    // start coincident with e in IDLE: that edge is not used
    sq_restart(50, 50);
    idle(52);
    push(100, 0, 0, 201);
    pulse_start();
    drain("t8");
    idle(200);
    chk("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of a slow, asynchronous square wave in CLKin cycles.
- It is the inverse of the frequency divider: the divider turns a cycle count into a toggling clock; this block turns a toggling signal back into a cycle count.
- It sits beside divided-clock and tick sources and is used for self-check and for display of the measured rate.
- Single-shot or continuous operation; a timeout flags dead or too-slow inputs.

Parameters:
- CNT_W, 32, width of the period counter and result.
- SYNC_STAGES, 2, flip-flop stages in the sig_in synchronizer (minimum 2).
- TIMEOUT, 50000000, maximum cycles waited in ARM or MEASURE before overflow is declared (must be less than 2^CNT_W).

Ports:
- CLKin, input, 1, system clock; all logic on its rising edge.
- clr, input, 1, reset, asynchronous, active-low.
- sig_in, input, 1, asynchronous signal under measurement.
- start, input, 1, single-cycle request to begin measuring.
- cont, input, 1, continuous mode; sampled each cycle in MEASURE.
- period, output, CNT_W, last measured period in CLKin cycles.
- valid, output, 1, one-cycle pulse when period/overflow are updated.
- overflow, output, 1, last result was a timeout; held until next valid.
- busy, output, 1, high in ARM or MEASURE.

Behaviour:
- Reset (clr low, asynchronous): state IDLE; period=0, valid=0, overflow=0, busy=0; counter=0; synchronizer and edge-history flops=0.
- Synchronizer: SYNC_STAGES flops on sig_in, then one history flop.
- Edge pulse e: synchronized value 1 and history 0. e asserts SYNC_STAGES+1 cycles after a sig_in rise.
- Falling edges are ignored.
- State IDLE:
  - start=1 → ARM, counter=0.
  - e is ignored in IDLE, including in the same cycle as start.
- State ARM (waiting for the first rising edge):
  - e=1 → MEASURE, counter=1.
  - Otherwise counter+1.
  - counter==TIMEOUT with e=0 → IDLE, period=0, overflow=1, valid=1.
- State MEASURE:
  - e=0: counter+1.
  - e=1: period=counter, overflow=0, valid=1. Then if cont=1 stay in MEASURE with counter=1, else → IDLE, counter=0.
  - Result equals the number of CLKin cycles between consecutive e pulses (a square wave of N cycles gives N).
  - counter==TIMEOUT with e=0 → IDLE, period=0, overflow=1, valid=1.
- Edge and timeout in the same cycle: the edge wins and the normal result is reported.
- valid is exactly one cycle wide. period and overflow hold their values between valid pulses.
- busy = (state==ARM or state==MEASURE), registered with the state.
- start while busy is ignored; a measurement in progress is never restarted.
- Clearing cont during continuous operation ends the run at the next completed period; no partial result is produced.
- The counter never wraps; TIMEOUT bounds it.
- Reset mid-operation aborts immediately to the reset values; no valid is emitted.

Test Plan:
- TIMEOUT=1000, sig_in square wave period 100 cycles, pulse start, cont=0 → exactly one valid, period=100, overflow=0, then busy=0.
- Same stimulus with cont=1 for 350 cycles after the first edge → three valid pulses 100 cycles apart, each period=100; cont dropped afterwards → one more result, then IDLE.
- sig_in held 0, start → valid with overflow=1, period=0 exactly 1001 cycles after start; busy falls the same cycle.
- Period 2000 (> TIMEOUT) → overflow in MEASURE, period=0.
- Edge arranged on the cycle counter==1000 → period=1000, overflow=0.
- Square wave running, pulse start, assert clr low mid-MEASURE → all outputs 0 immediately; new start after release measures correctly (period=100).
- start pulsed again while busy → ignored, result unchanged.
- start coincident with e in IDLE → that edge is not used; the first result corresponds to the next two edges.
